// File: rtl/quant_pkg.sv
// Shared constants, quantizer scale tables and helpers for the 4x4 forward quantizer.
package quant_pkg;

    localparam int unsigned QP_MAX   = 51;
    localparam int unsigned NUM_COEF = 16;
    localparam int unsigned MF_W     = 14;
    localparam int unsigned F_W      = 22;
    localparam int unsigned QBITS_W  = 5;

    typedef enum logic [1:0] {IDLE, CALC, DRAIN, DONE} state_e;
    typedef enum logic [1:0] {CLS_A = 2'd0, CLS_B = 2'd1, CLS_C = 2'd2} pos_class_e;

    // Rows indexed by qp%6, columns by position class A/B/C.
    localparam logic [MF_W-1:0] MF_TABLE [6][3] = '{
        '{14'd13107, 14'd5243, 14'd8066},
        '{14'd11916, 14'd4660, 14'd7490},
        '{14'd10082, 14'd4194, 14'd6554},
        '{14'd9362,  14'd3647, 14'd5825},
        '{14'd8192,  14'd3355, 14'd5243},
        '{14'd7282,  14'd2893, 14'd4559}
    };

    localparam logic [F_W-1:0] F_INTRA [9] = '{
        22'd10922, 22'd21845, 22'd43690, 22'd87381, 22'd174762,
        22'd349525, 22'd699050, 22'd1398101, 22'd2796202
    };
    localparam logic [F_W-1:0] F_INTER [9] = '{
        22'd5461, 22'd10922, 22'd21845, 22'd43690, 22'd87381,
        22'd174762, 22'd349525, 22'd699050, 22'd1398101
    };

    function automatic pos_class_e pos_class(input logic [3:0] idx);
        logic row_odd;
        logic col_odd;
        row_odd = idx[2];
        col_odd = idx[0];
        if (!row_odd && !col_odd) return CLS_A;
        if (row_odd && col_odd)   return CLS_B;
        return CLS_C;
    endfunction

    function automatic logic [3:0] qp_div6(input logic [5:0] qp);
        logic [3:0] d;
        d = '0;
        for (int unsigned k = 1; k <= 8; k++) begin
            if (qp >= 6'(6 * k)) d = 4'(k);
        end
        return d;
    endfunction

    function automatic logic [2:0] qp_mod6(input logic [5:0] qp, input logic [3:0] div);
        logic [5:0] base;
        base = 6'(div * 6);
        return 3'(qp - base);
    endfunction

    function automatic logic [F_W-1:0] round_offset(input logic [3:0] div, input logic intra);
        logic [3:0] d;
        d = (div > 4'd8) ? 4'd8 : div;
        return intra ? F_INTRA[d] : F_INTER[d];
    endfunction

endpackage

// File: rtl/quant_coef_pipe.sv
// Two-stage per-coefficient datapath: |coef|*MF, then round, shift, saturate and re-sign.
module quant_coef_pipe
    import quant_pkg::*;
#(
    parameter int unsigned COEF_W  = 32,
    parameter int unsigned LEVEL_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [3:0]                in_idx,
    input  logic signed [COEF_W-1:0]  coef,
    input  logic [MF_W-1:0]           mf,
    input  logic [F_W-1:0]            f,
    input  logic [QBITS_W-1:0]        qbits,
    output logic                      out_valid,
    output logic [3:0]                out_idx,
    output logic signed [LEVEL_W-1:0] level,
    output logic                      nz
);

    localparam int unsigned PROD_W = COEF_W + MF_W;
    localparam int unsigned SUM_W  = PROD_W + 1;
    localparam logic [SUM_W-1:0] LV_MAX = SUM_W'((1 << (LEVEL_W - 1)) - 1);

    logic [COEF_W-1:0]  mag;
    logic [PROD_W-1:0]  prod_d, prod_q;
    logic               v1_q, sign1_q;
    logic [3:0]         idx1_q;

    logic [SUM_W-1:0]         sum, shifted;
    logic [LEVEL_W-1:0]       lv_mag;
    logic signed [LEVEL_W-1:0] level_d, level_q;
    logic               v2_q, nz_q;
    logic [3:0]         idx2_q;

    // Magnitude is unsigned so the most negative input maps to 2^(COEF_W-1).
    always_comb begin
        mag    = coef[COEF_W-1] ? COEF_W'(-coef) : COEF_W'(coef);
        prod_d = PROD_W'(mag) * PROD_W'(mf);
    end

    always_comb begin
        sum     = SUM_W'(prod_q) + SUM_W'(f);
        shifted = sum >> qbits;
        lv_mag  = (shifted > LV_MAX) ? LEVEL_W'(LV_MAX) : LEVEL_W'(shifted);
        level_d = sign1_q ? -$signed(lv_mag) : $signed(lv_mag);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            idx1_q  <= '0;
            prod_q  <= '0;
            v2_q    <= 1'b0;
            idx2_q  <= '0;
            level_q <= '0;
            nz_q    <= 1'b0;
        end else begin
            v1_q    <= in_valid;
            sign1_q <= coef[COEF_W-1];
            idx1_q  <= in_idx;
            prod_q  <= prod_d;
            v2_q    <= v1_q;
            idx2_q  <= idx1_q;
            level_q <= level_d;
            nz_q    <= (lv_mag != '0);
        end
    end

    assign out_valid = v2_q;
    assign out_idx   = idx2_q;
    assign level     = level_q;
    assign nz        = nz_q;

endmodule

// File: rtl/quant_4x4.sv
// H.264-style forward quantizer for one 4x4 block: control FSM, coefficient issue and result array.
module quant_4x4
    import quant_pkg::*;
#(
    parameter int unsigned COEF_W  = 32,
    parameter int unsigned LEVEL_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COEF_W-1:0]  coef [15:0],
    input  logic [5:0]                qp,
    input  logic                      intra,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [LEVEL_W-1:0] level [15:0],
    output logic [4:0]                nz_count
);

    state_e state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       accept;

    logic signed [COEF_W-1:0]  coef_q  [NUM_COEF];
    logic signed [LEVEL_W-1:0] level_q [NUM_COEF];
    logic signed [LEVEL_W-1:0] level_d [NUM_COEF];
    logic [4:0] nz_q, nz_d;
    logic [3:0] qp_div_q;
    logic [2:0] qp_mod_q;
    logic       intra_q;

    logic [5:0]          qp_clamp, qp_div_tmp;
    logic [3:0]          qp_div_in;
    logic [MF_W-1:0]     mf;
    logic [F_W-1:0]      f;
    logic [QBITS_W-1:0]  qbits;

    logic                      pipe_v, pipe_nz;
    logic [3:0]                pipe_idx;
    logic signed [LEVEL_W-1:0] pipe_level;

    always_comb begin
        qp_clamp   = (qp > 6'(QP_MAX)) ? 6'(QP_MAX) : qp;
        qp_div_in  = qp_div6(qp_clamp);
        qp_div_tmp = 6'(qp_div_in);
        qbits      = QBITS_W'(15) + QBITS_W'(qp_div_q);
        f          = round_offset(qp_div_q, intra_q);
        mf         = MF_TABLE[qp_mod_q][pos_class(idx_q)];
    end

    // DRAIN waits for the last index to leave the second pipeline register, so it spans two cycles.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) state_d = DRAIN;
            end
            DRAIN: begin
                if (pipe_v && pipe_idx == 4'd15) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        nz_d    = nz_q;
        if (accept) begin
            for (int unsigned i = 0; i < NUM_COEF; i++) level_d[i] = '0;
            nz_d = '0;
        end else if (pipe_v) begin
            level_d[pipe_idx] = pipe_level;
            if (pipe_nz) nz_d = nz_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            nz_q     <= '0;
            qp_div_q <= '0;
            qp_mod_q <= '0;
            intra_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_COEF; i++) level_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nz_q    <= nz_d;
            level_q <= level_d;
            if (accept) begin
                qp_div_q <= qp_div_in;
                qp_mod_q <= qp_mod6(qp_clamp, qp_div_tmp[3:0]);
                intra_q  <= intra;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned i = 0; i < NUM_COEF; i++) coef_q[i] <= coef[i];
        end
    end

    quant_coef_pipe #(
        .COEF_W  (COEF_W),
        .LEVEL_W (LEVEL_W)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (state_q == CALC),
        .in_idx    (idx_q),
        .coef      (coef_q[idx_q]),
        .mf        (mf),
        .f         (f),
        .qbits     (qbits),
        .out_valid (pipe_v),
        .out_idx   (pipe_idx),
        .level     (pipe_level),
        .nz        (pipe_nz)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_COEF; i++) level[i] = level_q[i];
        nz_count = nz_q;
    end

endmodule
